// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: shifter FSM encoding, word sizes
// and the fill-select constants used by the right shifter.
package mips_pkg;

    localparam int WORD_W  = 32;
    localparam int SHAMT_W = 5;

    // arith input: 0 selects SRL (zero fill), 1 selects SRA (sign fill)
    localparam logic FILL_ZERO = 1'b0;
    localparam logic FILL_SIGN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Bits to shift this cycle: the smaller of the per-cycle step and what remains.
    function automatic int unsigned step_amount(input int unsigned cnt, input int unsigned step);
        return (cnt > step) ? step : cnt;
    endfunction

endpackage

// File: rtl/shift_right_step.sv
// One combinational right-shift slice: shifts data right by k (0..STEP)
// and replicates the fill bit into the vacated MSBs.
module shift_right_step
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int KW    = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        fill_mask = ~({WIDTH{1'b1}} >> k);
        result    = (data >> k) | (fill ? fill_mask : '0);
    end

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA/SRLV/SRAV shifter: captures an operand on start,
// shifts up to STEP bits per cycle, then holds the result with a done pulse.
module shift_right_seq #(
    parameter int WIDTH   = mips_pkg::WORD_W,
    parameter int SHAMT_W = mips_pkg::SHAMT_W,
    parameter int STEP    = 4
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic [WIDTH-1:0]   out,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    import mips_pkg::*;

    // Handshake: start acts as valid and !busy as ready; a request is
    // accepted only on an edge where start=1 and busy=0. Requests made
    // while busy are dropped, not queued, and operands are captured only
    // at acceptance. done marks the single cycle in which out is new.

    localparam int KW = $clog2(STEP + 1);
    localparam logic [SHAMT_W-1:0] STEP_CNT = SHAMT_W'(STEP);

    state_t             state, state_n;
    logic [WIDTH-1:0]   data_q, data_n;
    logic [SHAMT_W-1:0] cnt_q, cnt_n;
    logic               fill_q, fill_n;
    logic [WIDTH-1:0]   out_q, out_n;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   step_out;

    always_comb begin
        k = (cnt_q > STEP_CNT) ? KW'(STEP) : cnt_q[KW-1:0];
    end

    shift_right_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .data   (data_q),
        .k      (k),
        .fill   (fill_q),
        .result (step_out)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            data_q <= '0;
            cnt_q  <= '0;
            fill_q <= FILL_ZERO;
            out_q  <= '0;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            cnt_q  <= cnt_n;
            fill_q <= fill_n;
            out_q  <= out_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data_q;
        cnt_n   = cnt_q;
        fill_n  = fill_q;
        out_n   = out_q;
        case (state)
            IDLE: begin
                if (start) begin
                    data_n = in;
                    cnt_n  = shamt;
                    fill_n = (arith == FILL_SIGN) ? in[WIDTH-1] : FILL_ZERO;
                    if (shamt == '0) begin
                        // zero shift skips SHIFT and publishes the operand as-is
                        state_n = DONE;
                        out_n   = in;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_n = step_out;
                cnt_n  = cnt_q - SHAMT_W'(k);
                if (cnt_n == '0) begin
                    state_n = DONE;
                    out_n   = step_out;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        out       = out_q;
        busy      = (state != IDLE);
        done      = (state == DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: cycle model built from shift
// arithmetic and latency ceil(shamt/STEP), plus literal expectations.
module tb_shift_right_seq;

    localparam int W    = 32;
    localparam int SW   = 5;
    localparam int STEP = 4;

    logic          Clk;
    logic          Rst;
    logic          start;
    logic [W-1:0]  in_v;
    logic [SW-1:0] shamt;
    logic          arith;
    logic [W-1:0]  out;
    logic          busy;
    logic          done;
    logic [1:0]    dbg_state;

    int total;
    int bad;

    shift_right_seq #(
        .WIDTH   (W),
        .SHAMT_W (SW),
        .STEP    (STEP)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .in        (in_v),
        .shamt     (shamt),
        .arith     (arith),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_out;
    logic         m_busy;
    logic         m_done;
    int           m_left;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int s, input logic ar);
        logic signed [W-1:0] sa;
        sa = a;
        if (ar) return W'(sa >>> s);
        return a >> s;
    endfunction

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_out  = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_left = 0;
            exp_q.delete();
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_out  = exp_q.pop_front();
            end
        end else if (start) begin
            m_busy = 1'b1;
            exp_q.push_back(ref_shift(in_v, int'(shamt), arith));
            m_left = (int'(shamt) + STEP - 1) / STEP;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_out  = exp_q.pop_front();
            end
        end
    end

    task automatic check32(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        check32("cyc_out", out, m_out);
        check32("cyc_busy", W'(busy), W'(m_busy));
        check32("cyc_done", W'(done), W'(m_done));
    end

    // driver tasks
    task automatic issue(input logic [W-1:0] a, input logic [SW-1:0] s, input logic ar);
        @(negedge Clk);
        in_v  = a;
        shamt = s;
        arith = ar;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // Issue one op and wait for done; n counts negedges after the accepting edge.
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [SW-1:0] s,
                         input logic ar, input logic [W-1:0] exp_o, input int exp_n);
        int n;
        issue(a, s, ar);
        n = 1;
        while (!done && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check32({nm, "_done_seen"}, W'(done), 32'd1);
        check32({nm, "_latency"}, W'(n), W'(exp_n));
        check32({nm, "_out"}, out, exp_o);
    endtask

    initial begin
        int dones;
        total = 0;
        bad   = 0;
        Rst   = 1'b1;
        start = 1'b0;
        in_v  = '0;
        shamt = '0;
        arith = 1'b0;
        repeat (2) @(negedge Clk);
        check32("rst_out", out, 32'h0);
        check32("rst_busy", W'(busy), 32'd0);
        check32("rst_done", W'(done), 32'd0);
        check32("rst_state", W'(dbg_state), 32'd0);
        Rst = 1'b0;

        do_op("srl4", 32'h8000_0000, 5'd4, 1'b0, 32'h0800_0000, 2);
        do_op("sra4", 32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000, 2);
        do_op("sra31", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 9);
        do_op("zero", 32'h1234_5678, 5'd0, 1'b0, 32'h1234_5678, 1);
        do_op("srl31", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 9);
        do_op("sra7pos", 32'h7654_3210, 5'd7, 1'b1, 32'h00EC_A864, 3);
        do_op("sra13neg", 32'hC000_00FF, 5'd13, 1'b1, 32'hFFFE_0000, 5);

        // start while busy is ignored
        issue(32'h0000_F000, 5'd8, 1'b0);
        in_v  = 32'hFFFF_FFFF;
        shamt = 5'd1;
        arith = 1'b1;
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) dones++;
            @(negedge Clk);
        end
        check32("busy_ignore_dones", W'(dones), 32'd1);
        check32("busy_ignore_out", out, 32'h0000_00F0);
        check32("busy_ignore_idle", W'(busy), 32'd0);

        // asynchronous reset mid-SHIFT
        issue(32'hFFFF_0000, 5'd16, 1'b0);
        @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        check32("async_out", out, 32'h0);
        check32("async_busy", W'(busy), 32'd0);
        check32("async_done", W'(done), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            if (done) dones++;
        end
        check32("async_no_done", W'(dones), 32'd0);
        do_op("after_rst", 32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001, 3);

        // back-to-back: do_op starts in the first IDLE cycle after DONE
        do_op("b2b_a", 32'hA5A5_0000, 5'd12, 1'b1, 32'hFFFA_5A50, 4);
        do_op("b2b_b", 32'h0F00_0000, 5'd24, 1'b0, 32'h0000_000F, 7);

        repeat (3) @(negedge Clk);
        check32("hold_out", out, 32'h0000_000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
